// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 demultiplexer with per-channel FIFOs.
//   DB_DEFAULT   : default data width in bits
//   PROF_DEFAULT : default depth of each channel FIFO (power of 2, >= 2)
//   SEL_A/SEL_B  : Sel encoding, same polarity as the 2-input selector
package demux_pkg;

  localparam int unsigned DB_DEFAULT   = 16;
  localparam int unsigned PROF_DEFAULT = 4;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/fifo_sync_demux.sv
// Single-clock FIFO used as one output channel of the demultiplexer.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset (pointers and count cleared)
//   i_push   : write i_dato this edge (ignored when full or in reset)
//   i_pop    : advance read pointer this edge (ignored when empty)
//   i_dato   : write data
//   o_head   : word at the read pointer, 0 while empty
//   o_full   : count == PROF
//   o_empty  : count == 0
//   o_count  : number of words held
module fifo_sync_demux #(
  parameter int unsigned DB   = 16,
  parameter int unsigned PROF = 4,
  parameter int unsigned PW   = $clog2(PROF)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DB-1:0] i_dato,
  output logic [DB-1:0] o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW:0]   o_count
);

  logic [DB-1:0] r_mem [PROF];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PW+1)'(PROF));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_push = i_push & ~o_full & i_rst_n;
  assign w_pop  = i_pop & ~o_empty;

  // Storage is not reset; gating the head on empty keeps the output at 0
  // until the first word written after reset becomes visible.
  assign o_head = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_dato;
  end

endmodule

// File: rtl/demultiplexor_1out_2in_fifo.sv
// Routes one valid/ready input stream to channel A or B, chosen per word by
// Sel, with an independent FIFO per channel so one stalled consumer does not
// block the other.
// Ports:
//   clk, reset      : clock (rising edge), synchronous active-low reset
//   Dato, Sel       : input word and destination (1 = A, 0 = B)
//   ValidoEntrada   : input word present
//   ListoEntrada    : selected channel can accept (combinational on Sel)
//   SalidaA/B       : head word of each FIFO
//   ValidoA/B       : FIFO not empty
//   ListoA/B        : consumer accepts head word
//   OcupA/B         : words held in each FIFO
module demultiplexor_1out_2in_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DB   = DB_DEFAULT,
  parameter int unsigned PROF = PROF_DEFAULT,
  parameter int unsigned PW   = $clog2(PROF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DB-1:0] Dato,
  input  logic          Sel,
  input  logic          ValidoEntrada,
  output logic          ListoEntrada,
  output logic [DB-1:0] SalidaA,
  output logic          ValidoA,
  input  logic          ListoA,
  output logic [DB-1:0] SalidaB,
  output logic          ValidoB,
  input  logic          ListoB,
  output logic [PW:0]   OcupA,
  output logic [PW:0]   OcupB
);

  logic w_sel_a;
  logic w_full_a;
  logic w_full_b;
  logic w_empty_a;
  logic w_empty_b;
  logic w_push_a;
  logic w_push_b;
  logic w_pop_a;
  logic w_pop_b;

  assign w_sel_a = (Sel == SEL_A);

  // Ready depends on the current fill level only; a pop on the same edge
  // does not free a slot for the incoming word.
  assign ListoEntrada = reset & (w_sel_a ? ~w_full_a : ~w_full_b);

  assign w_push_a = ValidoEntrada & ListoEntrada &  w_sel_a;
  assign w_push_b = ValidoEntrada & ListoEntrada & ~w_sel_a;

  assign ValidoA = ~w_empty_a;
  assign ValidoB = ~w_empty_b;
  assign w_pop_a = ValidoA & ListoA;
  assign w_pop_b = ValidoB & ListoB;

  fifo_sync_demux #(.DB(DB), .PROF(PROF), .PW(PW)) u_fifo_a (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push_a),
    .i_pop   (w_pop_a),
    .i_dato  (Dato),
    .o_head  (SalidaA),
    .o_full  (w_full_a),
    .o_empty (w_empty_a),
    .o_count (OcupA)
  );

  fifo_sync_demux #(.DB(DB), .PROF(PROF), .PW(PW)) u_fifo_b (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push_b),
    .i_pop   (w_pop_b),
    .i_dato  (Dato),
    .o_head  (SalidaB),
    .o_full  (w_full_b),
    .o_empty (w_empty_b),
    .o_count (OcupB)
  );

endmodule

// File: tb/tb_demultiplexor_1out_2in_fifo.sv
module tb_demultiplexor_1out_2in_fifo;

  localparam int unsigned DB   = 16;
  localparam int unsigned PROF = 4;
  localparam int unsigned PW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] Dato;
  logic          Sel;
  logic          ValidoEntrada;
  logic          ListoEntrada;
  logic [DB-1:0] SalidaA;
  logic          ValidoA;
  logic          ListoA;
  logic [DB-1:0] SalidaB;
  logic          ValidoB;
  logic          ListoB;
  logic [PW:0]   OcupA;
  logic [PW:0]   OcupB;

  demultiplexor_1out_2in_fifo #(.DB(DB), .PROF(PROF), .PW(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .Dato          (Dato),
    .Sel           (Sel),
    .ValidoEntrada (ValidoEntrada),
    .ListoEntrada  (ListoEntrada),
    .SalidaA       (SalidaA),
    .ValidoA       (ValidoA),
    .ListoA        (ListoA),
    .SalidaB       (SalidaB),
    .ValidoB       (ValidoB),
    .ListoB        (ListoB),
    .OcupA         (OcupA),
    .OcupB         (OcupB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          v;
    logic          s;
    logic [DB-1:0] d;
    logic          la;
    logic          lb;
    logic          el;
    int            eoa;
    int            eob;
  } vec_t;

  vec_t tbl[$];

  // Scoreboard: expected contents of each channel, in order.
  logic [DB-1:0] qA[$];
  logic [DB-1:0] qB[$];
  logic          wrA;
  logic          wrB;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, v, s, input logic [DB-1:0] d, input logic la, lb,
                     input logic el, input int eoa, eob);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.la = la; t.lb = lb;
    t.el = el; t.eoa = eoa; t.eob = eob;
    tbl.push_back(t);
  endtask

  // Drive one cycle of inputs, check pre-edge outputs against the model
  // (and optional fixed table expectations), then advance the model.
  task automatic do_cycle(input logic r, v, s, input logic [DB-1:0] d,
                          input logic la, lb, input bit has_exp,
                          input logic el, input int eoa, eob);
    logic exp_listo, pop_a, pop_b, push_a, push_b;
    reset = r; ValidoEntrada = v; Sel = s; Dato = d; ListoA = la; ListoB = lb;
    #1;
    exp_listo = r & (s ? (qA.size() < PROF) : (qB.size() < PROF));
    chk("ListoEntrada", 32'(ListoEntrada), 32'(exp_listo));
    chk("ValidoA", 32'(ValidoA), 32'(qA.size() != 0));
    chk("ValidoB", 32'(ValidoB), 32'(qB.size() != 0));
    chk("OcupA", 32'(OcupA), 32'(qA.size()));
    chk("OcupB", 32'(OcupB), 32'(qB.size()));
    if (qA.size() != 0)  chk("SalidaA", 32'(SalidaA), 32'(qA[0]));
    else if (!wrA)       chk("SalidaA_rst0", 32'(SalidaA), 32'h0);
    if (qB.size() != 0)  chk("SalidaB", 32'(SalidaB), 32'(qB[0]));
    else if (!wrB)       chk("SalidaB_rst0", 32'(SalidaB), 32'h0);
    if (has_exp) begin
      chk("tbl_ListoEntrada", 32'(ListoEntrada), 32'(el));
      chk("tbl_OcupA", 32'(OcupA), 32'(eoa));
      chk("tbl_OcupB", 32'(OcupB), 32'(eob));
    end
    pop_a  = (qA.size() != 0) & la;
    pop_b  = (qB.size() != 0) & lb;
    push_a = v & exp_listo &  s;
    push_b = v & exp_listo & ~s;
    @(posedge clk);
    if (!r) begin
      qA.delete(); qB.delete(); wrA = 1'b0; wrB = 1'b0;
    end else begin
      if (pop_a)  void'(qA.pop_front());
      if (pop_b)  void'(qB.pop_front());
      if (push_a) begin qA.push_back(d); wrA = 1'b1; end
      if (push_b) begin qB.push_back(d); wrB = 1'b1; end
    end
    #1;
  endtask

  initial begin
    logic          sv, ss, stall;
    logic [DB-1:0] sd;

    // Reset hold, then release
    add(0,1,1,16'hFFFF,0,0, 0,0,0);
    add(0,1,1,16'hFFFF,0,0, 0,0,0);
    add(0,1,1,16'hFFFF,0,0, 0,0,0);
    add(1,0,1,16'h0000,0,0, 1,0,0);
    // Routing
    add(1,1,1,16'h1111,0,0, 1,0,0);
    add(1,1,0,16'h2222,0,0, 1,1,0);
    add(1,1,1,16'h3333,0,0, 1,1,1);
    add(1,0,1,16'h0000,1,1, 1,2,1);
    add(1,0,1,16'h0000,1,1, 1,1,0);
    add(1,0,1,16'h0000,0,0, 1,0,0);
    // Full, backpressure, other channel still open, wrap
    add(1,1,1,16'hA000,0,0, 1,0,0);
    add(1,1,1,16'hA001,0,0, 1,1,0);
    add(1,1,1,16'hA002,0,0, 1,2,0);
    add(1,1,1,16'hA003,0,0, 1,3,0);
    add(1,1,1,16'hA004,0,0, 0,4,0);
    add(1,1,0,16'hB000,0,0, 1,4,0);
    add(1,1,1,16'hA004,1,0, 0,4,1);
    add(1,1,1,16'hA004,0,1, 1,3,1);
    add(1,0,1,16'h0000,1,0, 0,4,0);
    add(1,0,1,16'h0000,1,0, 1,3,0);
    add(1,0,1,16'h0000,1,0, 1,2,0);
    add(1,0,1,16'h0000,1,0, 1,1,0);
    add(1,0,1,16'h0000,0,0, 1,0,0);
    // Simultaneous push/pop, not full
    add(1,1,1,16'hC000,0,0, 1,0,0);
    add(1,1,1,16'hC001,0,0, 1,1,0);
    add(1,1,1,16'hC002,1,0, 1,2,0);
    add(1,0,1,16'h0000,0,0, 1,2,0);
    // Simultaneous push/pop, full
    add(1,1,1,16'hC003,0,0, 1,2,0);
    add(1,1,1,16'hC004,0,0, 1,3,0);
    add(1,1,1,16'hC005,1,0, 0,4,0);
    add(1,0,1,16'h0000,0,0, 1,3,0);
    add(1,0,1,16'h0000,1,0, 1,3,0);
    add(1,0,1,16'h0000,1,0, 1,2,0);
    add(1,0,1,16'h0000,1,0, 1,1,0);
    add(1,0,1,16'h0000,0,0, 1,0,0);
    // Mid-operation reset
    add(1,1,1,16'h0001,0,0, 1,0,0);
    add(1,1,1,16'h0002,0,0, 1,1,0);
    add(1,1,1,16'h0003,0,0, 1,2,0);
    add(1,1,0,16'h0004,0,0, 1,3,0);
    add(1,0,1,16'h0000,0,0, 1,3,1);
    add(0,0,1,16'h0000,0,0, 0,3,1);
    add(1,0,1,16'h0000,0,0, 1,0,0);
    add(1,1,1,16'h5A5A,0,0, 1,0,0);
    add(1,0,1,16'h0000,1,0, 1,1,0);
    add(1,0,1,16'h0000,0,0, 1,0,0);

    wrA = 1'b0; wrB = 1'b0;
    reset = 1'b0; ValidoEntrada = 1'b0; Sel = 1'b0; Dato = '0;
    ListoA = 1'b0; ListoB = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      do_cycle(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].la, tbl[i].lb,
               1'b1, tbl[i].el, tbl[i].eoa, tbl[i].eob);

    // Random soak, honouring the producer hold rule while stalled
    sv = 1'b0; ss = 1'b0; sd = '0; stall = 1'b0;
    for (int unsigned n = 0; n < 2000; n++) begin
      if (!stall) begin
        sv = 1'($urandom_range(0, 1));
        ss = 1'($urandom_range(0, 1));
        sd = DB'($urandom);
      end
      stall = sv & !(ss ? (qA.size() < PROF) : (qB.size() < PROF));
      do_cycle(1'b1, sv, ss, sd, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 2) == 0), 1'b0, 1'b0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
